// File: rtl/cp0_pkg.sv
// ---------------------------------------------------------------------------
// cp0_pkg
//   Shared CP0 constants used by the interrupt front-end and by CP0 itself:
//   register numbers, Cause bit positions, and the ext_int bit that carries
//   the timer interrupt. Also holds the 32-bit increment helper used by the
//   Count/Compare timer.
// ---------------------------------------------------------------------------
package cp0_pkg;

  localparam int unsigned CP0_REG_COUNT   = 32'd9;
  localparam int unsigned CP0_REG_COMPARE = 32'd11;
  localparam int unsigned CP0_REG_CAUSE   = 32'd13;

  localparam int unsigned CAUSE_IP_LSB    = 32'd10;
  localparam int unsigned CAUSE_TI_BIT    = 32'd30;

  localparam int unsigned NUM_HW_INT      = 32'd6;
  localparam int unsigned IP_TIMER_IDX    = 32'd5;

  // Count increment; wraps silently from 32'hFFFF_FFFF to 0.
  function automatic logic [31:0] count_inc(input logic [31:0] value);
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/cp0_int_ctrl_int_sync.sv
// ---------------------------------------------------------------------------
// int_sync
//   Single-bit synchroniser for one asynchronous interrupt line.
//   Ports:
//     clk  in  core clock
//     rst  in  asynchronous reset, active-high (clears every stage)
//     d    in  raw asynchronous input
//     q    out synchronised output (last stage)
//   STAGES must be at least 2.
// ---------------------------------------------------------------------------
module int_sync #(
  parameter int unsigned STAGES = 32'd2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the raw line through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/cp0_int_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_int_ctrl
//   Interrupt front-end for CP0 Cause.IP[7:2]. Synchronises six hardware
//   interrupt lines, latches edge-mode lines until acknowledged, and owns the
//   Count/Compare timer whose interrupt is merged into ext_int[5] (IP7).
//   Ports:
//     clk, rst                    core clock, async active-high reset
//     hw_int_in[5:0]              raw async interrupt lines
//     edge_clr[5:0]               per-line edge-latch acknowledge pulse
//     count_we / count_wdata      MTC0 Count commit
//     compare_we / compare_wdata  MTC0 Compare commit (also acks the timer)
//     ext_int[5:0]                registered interrupt vector to Cause[15:10]
//     timer_int                   registered Cause.TI
//     count / compare             current timer registers
//   SYNC_STAGES: 2..3, COUNT_DIV: 1..16, EDGE_MASK bit = 1 selects edge mode.
// ---------------------------------------------------------------------------
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 32'd2,
  parameter int unsigned COUNT_DIV   = 32'd2,
  parameter logic [5:0]  EDGE_MASK   = 6'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int_in,
  input  logic [5:0]  edge_clr,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic        compare_we,
  input  logic [31:0] compare_wdata,
  output logic [5:0]  ext_int,
  output logic        timer_int,
  output logic [31:0] count,
  output logic [31:0] compare
);

  localparam int unsigned DIV_W = (COUNT_DIV > 32'd1) ? $clog2(COUNT_DIV) : 32'd1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 32'd1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(32'd0);

  logic [5:0]       sync_s;
  logic [5:0]       sync_d_r;
  logic [5:0]       edge_latch_r;
  logic [5:0]       edge_set_s;
  logic [5:0]       pend_s;
  logic [5:0]       ext_next_s;
  logic [DIV_W-1:0] div_r;
  logic             tick_s;
  logic             match_s;
  logic             ti_r;

  for (genvar g = 0; g < 6; g++) begin : g_sync
    int_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (hw_int_in[g]),
      .q   (sync_s[g])
    );
  end

  // Rising-edge detect on edge lines and per-line pending selection.
  always_comb begin
    edge_set_s = sync_s & ~sync_d_r & EDGE_MASK;
    pend_s     = (edge_latch_r & EDGE_MASK) | (sync_s & ~EDGE_MASK);
    ext_next_s = pend_s;
    ext_next_s[IP_TIMER_IDX] = pend_s[IP_TIMER_IDX] | ti_r;
  end

  // Edge latches: a new edge beats a same-cycle acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_d_r     <= 6'h00;
      edge_latch_r <= 6'h00;
    end else begin
      sync_d_r     <= sync_s;
      edge_latch_r <= edge_set_s | (edge_latch_r & ~(edge_clr & EDGE_MASK));
    end
  end

  // Count prescaler tick and the match condition, which is only evaluated
  // on a real increment so a direct write onto the match value is silent.
  always_comb begin
    tick_s  = (div_r == DIV_LAST);
    match_s = tick_s & ~count_we & (count_inc(count) == compare);
  end

  // Free-running divider; Count writes leave its phase untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= DIV_ZERO;
    end else if (tick_s) begin
      div_r <= DIV_ZERO;
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // Count/Compare registers and the internal timer-pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= 32'd0;
      compare <= 32'd0;
      ti_r    <= 1'b0;
    end else begin
      if (count_we) begin
        count <= count_wdata;
      end else if (tick_s) begin
        count <= count_inc(count);
      end else begin
        count <= count;
      end

      if (compare_we) begin
        compare <= compare_wdata;
        ti_r    <= 1'b0;
      end else if (match_s) begin
        ti_r    <= 1'b1;
      end else begin
        ti_r    <= ti_r;
      end
    end
  end

  // Registered interrupt outputs; timer_int and ext_int[5] move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_int   <= 6'h00;
      timer_int <= 1'b0;
    end else begin
      ext_int   <= ext_next_s;
      timer_int <= ti_r;
    end
  end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
module tb_cp0_int_ctrl;

  localparam int S   = 2;
  localparam int DIV = 2;
  localparam logic [5:0] EM = 6'h09;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  hw_int_in = 6'h00;
  logic [5:0]  edge_clr = 6'h00;
  logic        count_we = 1'b0;
  logic [31:0] count_wdata = 32'd0;
  logic        compare_we = 1'b0;
  logic [31:0] compare_wdata = 32'd0;
  logic [5:0]  ext_int;
  logic        timer_int;
  logic [31:0] count;
  logic [31:0] compare;

  int checks = 0;
  int errors = 0;

  cp0_int_ctrl #(.SYNC_STAGES(S), .COUNT_DIV(DIV), .EDGE_MASK(EM)) dut (
    .clk(clk), .rst(rst), .hw_int_in(hw_int_in), .edge_clr(edge_clr),
    .count_we(count_we), .count_wdata(count_wdata),
    .compare_we(compare_we), .compare_wdata(compare_wdata),
    .ext_int(ext_int), .timer_int(timer_int), .count(count), .compare(compare)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- behavioural model ----------------
  // hh[j] holds the raw line value sampled j edges ago (hh[0] = this edge).
  logic [5:0]  hh [0:7];
  logic [5:0]  lat_m;
  logic [5:0]  e_ext;
  logic        e_tint;
  logic        ti_m;
  logic [31:0] cnt_m;
  logic [31:0] cmp_m;
  int          cyc_m;
  bit          model_ok = 1'b0;

  initial begin
    logic tick;
    logic [5:0] set;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int j = 0; j < 8; j++) hh[j] = 6'h00;
        lat_m = 6'h00; e_ext = 6'h00; e_tint = 1'b0; ti_m = 1'b0;
        cnt_m = 32'd0; cmp_m = 32'd0; cyc_m = 0;
      end else begin
        for (int j = 7; j > 0; j--) hh[j] = hh[j-1];
        hh[0] = hw_int_in;
        // level lines show the line as it was S edges ago; edge lines show the latch
        for (int i = 0; i < 6; i++) e_ext[i] = EM[i] ? lat_m[i] : hh[S][i];
        e_ext[5] = e_ext[5] | ti_m;
        e_tint = ti_m;
        set = hh[S] & ~hh[S+1] & EM;
        lat_m = set | (lat_m & ~(edge_clr & EM));
        cyc_m++;
        tick = ((cyc_m % DIV) == 0);
        if (compare_we) ti_m = 1'b0;
        else if (tick && !count_we && (cnt_m + 32'd1) == cmp_m) ti_m = 1'b1;
        if (count_we) cnt_m = count_wdata;
        else if (tick) cnt_m = cnt_m + 32'd1;
        if (compare_we) cmp_m = compare_wdata;
      end
      model_ok = 1'b1;
    end
  end

  // Every-cycle comparison against the model (zeros while reset is held).
  always @(negedge clk) begin
    if (model_ok) begin
      if (rst) begin
        chk("rst_ext", {26'd0, ext_int}, 32'd0);
        chk("rst_cnt", count, 32'd0);
      end else begin
        chk("m_ext", {26'd0, ext_int}, {26'd0, e_ext});
        chk("m_tint", {31'd0, timer_int}, {31'd0, e_tint});
        chk("m_count", count, cnt_m);
        chk("m_compare", compare, cmp_m);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    bit done;
    step(2);
    chk("reset_ext", {26'd0, ext_int}, 32'd0);
    chk("reset_tint", {31'd0, timer_int}, 32'd0);
    chk("reset_count", count, 32'd0);
    chk("reset_compare", compare, 32'd0);

    // 1: mid-count async reset with compare=5
    rst = 1'b0; compare_we = 1'b1; compare_wdata = 32'd5;
    step(1);
    compare_we = 1'b0;
    chk("t1_cmp5", compare, 32'd5);
    chk("t1_cnt0", count, 32'd0);
    step(1);
    chk("t1_cnt1", count, 32'd1);
    step(3);
    chk("t1_cnt2", count, 32'd2);
    #1; rst = 1'b1; #1;
    chk("t1_async_cnt", count, 32'd0);
    chk("t1_async_cmp", compare, 32'd0);
    chk("t1_async_ext", {26'd0, ext_int}, 32'd0);
    chk("t1_async_ti", {31'd0, timer_int}, 32'd0);
    step(1);
    rst = 1'b0;
    for (int j = 1; j <= DIV; j++) begin
      step(1);
      chk("t1_first_inc", count, (j == DIV) ? 32'd1 : 32'd0);
    end

    // 2: level line 2 held high for 10 cycles
    hw_int_in[2] = 1'b1;
    for (int j = 1; j <= S + 11; j++) begin
      step(1);
      if (j == 10) hw_int_in[2] = 1'b0;
      chk("t2_level", {31'd0, ext_int[2]}, (j >= S + 1 && j <= S + 10) ? 32'd1 : 32'd0);
    end

    // 3: edge line 0
    hw_int_in[0] = 1'b1;
    for (int j = 1; j <= S + 3; j++) begin
      step(1);
      hw_int_in[0] = 1'b0;
      chk("t3_edge_latch", {31'd0, ext_int[0]}, (j >= S + 2) ? 32'd1 : 32'd0);
    end
    hw_int_in[0] = 1'b1;
    step(1);
    hw_int_in[0] = 1'b0;
    step(S - 1);
    edge_clr[0] = 1'b1;
    step(1);
    edge_clr[0] = 1'b0;
    step(1);
    chk("t3_set_wins", {31'd0, ext_int[0]}, 32'd1);
    edge_clr[0] = 1'b1;
    step(1);
    edge_clr[0] = 1'b0;
    chk("t3_clr_lag", {31'd0, ext_int[0]}, 32'd1);
    step(1);
    chk("t3_clr", {31'd0, ext_int[0]}, 32'd0);

    // 4: timer match at compare=3 (ticks on even edges after reset)
    rst = 1'b1; step(1); rst = 1'b0;
    compare_we = 1'b1; compare_wdata = 32'd3;
    step(1);
    compare_we = 1'b0;
    step(5);
    chk("t4_cnt3", count, 32'd3);
    chk("t4_ti_lag", {31'd0, timer_int}, 32'd0);
    step(1);
    chk("t4_ti", {31'd0, timer_int}, 32'd1);
    chk("t4_ip7", {31'd0, ext_int[5]}, 32'd1);
    compare_we = 1'b1; compare_wdata = 32'd100;
    step(1);
    compare_we = 1'b0;
    chk("t4_ack_lag", {31'd0, timer_int}, 32'd1);
    step(1);
    chk("t4_ack_ti", {31'd0, timer_int}, 32'd0);
    chk("t4_ack_ip7", {31'd0, ext_int[5]}, 32'd0);

    // 5: wrap with compare=0
    count_we = 1'b1; count_wdata = 32'hFFFF_FFFE;
    compare_we = 1'b1; compare_wdata = 32'd0;
    step(1);
    count_we = 1'b0; compare_we = 1'b0;
    chk("t5_wr", count, 32'hFFFF_FFFE);
    done = 1'b0;
    for (int n = 0; n < 4 * DIV + 4 && !done; n++) begin
      step(1);
      if (count == 32'd0) done = 1'b1;
    end
    chk("t5_wrap_reached", {31'd0, done}, 32'd1);
    chk("t5_ti_lag", {31'd0, timer_int}, 32'd0);
    step(1);
    chk("t5_ti", {31'd0, timer_int}, 32'd1);

    // 6: conflicts
    rst = 1'b1; step(1); rst = 1'b0;
    compare_we = 1'b1; compare_wdata = 32'd10;
    step(1);
    compare_we = 1'b0; count_we = 1'b1; count_wdata = 32'd50;
    step(1);
    count_we = 1'b0;
    chk("t6_we_over_tick", count, 32'd50);
    step(1);
    count_we = 1'b1; count_wdata = 32'd10;
    step(1);
    count_we = 1'b0;
    chk("t6_wr_eq_cmp", count, 32'd10);
    step(1);
    chk("t6_no_ti_on_wr", {31'd0, timer_int}, 32'd0);
    compare_we = 1'b1; compare_wdata = 32'd12;
    step(1);
    compare_we = 1'b0;
    step(1);
    compare_we = 1'b1; compare_wdata = 32'd12;
    step(1);
    compare_we = 1'b0;
    chk("t6_cnt12", count, 32'd12);
    step(2);
    chk("t6_clr_wins", {31'd0, timer_int}, 32'd0);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 7) == 0) hw_int_in[b] = ~hw_int_in[b];
      edge_clr = 6'($urandom & $urandom);
      count_we = ($urandom_range(0, 40) == 0);
      case ($urandom_range(0, 3))
        0:       count_wdata = cmp_m - 32'd1;
        1:       count_wdata = cmp_m;
        2:       count_wdata = 32'hFFFF_FFFE;
        default: count_wdata = $urandom;
      endcase
      compare_we = ($urandom_range(0, 30) == 0);
      compare_wdata = cnt_m + 32'($urandom_range(0, 6));
      step(1);
    end
    count_we = 1'b0; compare_we = 1'b0; edge_clr = 6'h00;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
